// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: imem request/response, redirect,
// and the valid/ready instruction output to decode.
interface inst_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem
// fetch, held output register to decode, redirect flush.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input logic          clk,
    input logic          rst_n,
    inst_fetch_if.master bus
);
    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic [1:0]  state;
    logic [31:0] pc;
    logic        discard;
    logic [31:0] target;
    logic        unused_bits;

    assign target      = {bus.redirect_pc[31:2], 2'b00};
    assign unused_bits = ^bus.redirect_pc[1:0];

    assign bus.imem_req_valid = (state == FETCH);
    assign bus.imem_req_addr  = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            discard        <= 1'b0;
            bus.inst_valid <= 1'b0;
            bus.inst       <= NOP;
            bus.inst_pc    <= RESET_PC;
        end else begin
            unique case (state)
                FETCH: begin
                    if (bus.redirect_valid) begin
                        pc <= target;
                        if (bus.imem_req_ready) begin
                            state   <= WAIT;
                            discard <= 1'b1;
                        end
                    end else if (bus.imem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // a response coinciding with redirect is the stale one
                    if (bus.redirect_valid) begin
                        pc <= target;
                        if (bus.imem_rsp_valid) begin
                            state   <= FETCH;
                            discard <= 1'b0;
                        end else begin
                            discard <= 1'b1;
                        end
                    end else if (bus.imem_rsp_valid) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= FETCH;
                        end else begin
                            bus.inst       <= bus.imem_rsp_data;
                            bus.inst_pc    <= pc;
                            bus.inst_valid <= 1'b1;
                            state          <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid) begin
                        bus.inst_valid <= 1'b0;
                        pc             <= target;
                        state          <= FETCH;
                    end else if (bus.inst_ready) begin
                        bus.inst_valid <= 1'b0;
                        pc             <= pc + PC_INC;
                        state          <= FETCH;
                    end
                end
                default: begin
                    state   <= FETCH;
                    discard <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage that sits directly upstream of the instruction decoder. It holds the program counter and issues word fetches to instruction memory over a request/response handshake. Each returned 32-bit instruction, with its PC, is presented to decode through a valid/ready output register. Branch/jump redirects from later stages flush any in-flight or held instruction and restart fetch at the target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
PC_INC, 4, byte increment applied to PC after each accepted instruction.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request this cycle.
imem_req_addr  output  32  word-aligned fetch address (= PC).
imem_rsp_valid  input  1  single-cycle pulse: response data valid.
imem_rsp_data  input  32  fetched instruction word.
redirect_valid  input  1  single-cycle pulse: flush and restart fetch.
redirect_pc  input  32  new fetch target; bits [1:0] ignored (forced 2'b00).
inst_valid  output  1  instruction available to decode.
inst_ready  input  1  decode consumes instruction this cycle.
inst  output  32  instruction word to decoder.
inst_pc  output  32  PC of the presented instruction.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, state=FETCH, discard=0.
  - inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC.
  - imem_req_valid is combinationally 1 in FETCH, so it is high from the first cycle after release.
- States:
  - FETCH: imem_req_valid=1, imem_req_addr=pc. On req_valid&req_ready go to WAIT.
  - WAIT: request outstanding, imem_req_valid=0. On imem_rsp_valid:
    - discard=1: drop data, clear discard, go to FETCH.
    - discard=0: latch inst=rsp_data and inst_pc=pc, set inst_valid=1, go to HOLD.
  - HOLD: inst_valid=1, outputs stable. On inst_valid&inst_ready: inst_valid=0, pc=pc+PC_INC, go to FETCH.
- At most one request outstanding; no new request is issued until the response returns.
- Memory latency is arbitrary (≥1 cycle after acceptance).
- Best-case throughput: one instruction per 3 cycles with zero-wait memory (FETCH→WAIT→HOLD).
- imem_req_addr and pc are stable while imem_req_valid=1 and not accepted.
- Redirect (redirect_valid=1) has priority over every other event in the same cycle:
  - FETCH: pc={redirect_pc[31:2],2'b00}. If the request is accepted that same cycle, go to WAIT with discard=1. Otherwise stay in FETCH; the request address changes next cycle.
  - WAIT: pc=target, discard=1. If imem_rsp_valid arrives the same cycle, that response is dropped, discard stays 0, and the state goes to FETCH.
  - HOLD: inst_valid=0 next cycle, pc=target, go to FETCH. This applies even if inst_ready=1 that cycle; pc is not incremented, and decode is flushed by the same redirect.
- inst_pc increments modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
- Async reset mid-operation returns to the reset state immediately, and any outstanding memory response is ignored:
  - A response arriving in FETCH or HOLD is never latched.
  - Memory must not return responses for requests issued before reset.
- inst and inst_pc change only on the WAIT→HOLD transition.

Test Plan:
- Reset with RESET_PC=32'h100, zero-latency memory returning addr^32'hA5A5_0000, inst_ready=1 always. Required:
  - imem_req_addr sequence is 0x100, 0x104, 0x108.
  - inst sequence is 0xA5A5_0100, 0xA5A5_0104, 0xA5A5_0108 with matching inst_pc.
  - One instruction every 3 cycles.
- Backpressure: inst_ready=0 for 5 cycles while in HOLD at pc 0x104. Required:
  - inst and inst_pc are stable for 5 cycles.
  - No imem request is issued.
  - After inst_ready=1, the next request goes to 0x108.
- Redirect in WAIT with 4-cycle memory latency: request at 0x200 accepted, redirect_pc=0x403 two cycles later. Required:
  - The 0x200 response is dropped.
  - The next request goes to 0x400.
  - The first inst_pc presented after the redirect is 0x400.
- Redirect in the same cycle as the response, and redirect in HOLD with inst_ready=1. Required:
  - Neither the response nor the held instruction is presented.
  - The next fetch goes to the target.
  - pc is not incremented past the target.
- Wrap: RESET_PC=32'hFFFF_FFFC, two instructions consumed. Required:
  - inst_pc sequence is 0xFFFF_FFFC, then 0x0000_0000.
- rst_n asserted while in WAIT, with a response pulse occurring during reset. Required:
  - inst_valid=0 immediately.
  - After release, the first request goes to RESET_PC and inst_valid stays 0 until a new response arrives.
